// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
module alu_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_a,
    input  logic [DATA_WIDTH-1:0]    req0_b,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_a,
    input  logic [DATA_WIDTH-1:0]    req1_b,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     rsp_id,
    output logic                     rsp_err,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    output logic [15:0]              op_count0,
    output logic [15:0]              op_count1
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_NE  = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_LT  = OPCODE_LENGTH'(4'b1010);
    localparam logic [OPCODE_LENGTH-1:0] OP_GE  = OPCODE_LENGTH'(4'b1011);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b1100);

    logic [0:0] state;
    logic       last_grant;
    logic       any_valid;
    logic       win_id;
    logic       accept;
    logic       op_supported;

    assign rsp_valid = (state == RESP);

    // Winner selection: a lone requester wins, a tie goes to whoever was not granted last
    always_comb begin
        any_valid = req0_valid | req1_valid;
        win_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            win_id = ~last_grant;
        end else if (req1_valid) begin
            win_id = 1'b1;
        end
        accept     = (state == IDLE) && any_valid;
        req0_ready = accept && !win_id;
        req1_ready = accept && win_id;
    end

    // Steer the winner's operands onto the shared ALU; idle the ALU inputs otherwise
    always_comb begin
        alu_srca = '0;
        alu_srcb = '0;
        alu_op   = '0;
        if (accept) begin
            if (win_id) begin
                alu_srca = req1_a;
                alu_srcb = req1_b;
                alu_op   = req1_op;
            end else begin
                alu_srca = req0_a;
                alu_srcb = req0_b;
                alu_op   = req0_op;
            end
        end
    end

    // Flag opcodes the shared ALU does not implement so their result is suppressed
    always_comb begin
        op_supported = 1'b0;
        case (alu_op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_EQ,
            OP_NE, OP_LT, OP_GE, OP_XOR: op_supported = 1'b1;
            default:                     op_supported = 1'b0;
        endcase
    end

    // Capture the ALU result on accept, hold it until consumed, then count it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
            op_count0  <= 16'd0;
            op_count1  <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        rsp_data   <= op_supported ? alu_result : '0;
                        rsp_err    <= ~op_supported;
                        rsp_id     <= win_id;
                        last_grant <= win_id;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                        if (rsp_id) begin
                            op_count1 <= op_count1 + 16'd1;
                        end else begin
                            op_count0 <= op_count0 + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic        rsp_valid, rsp_id, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data, alu_srca, alu_srcb, alu_result;
    logic [3:0]  alu_op;
    logic [15:0] op_count0, op_count1;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_c0 = 16'd0;
    logic [15:0] exp_c1 = 16'd0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op), .alu_result(alu_result),
        .op_count0(op_count0), .op_count1(op_count1)
    );

    // Shared ALU; unsupported codes return a junk pattern the arbiter must discard
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        case (alu_op)
            4'h0: alu_result = alu_srca & alu_srcb;
            4'h1: alu_result = alu_srca | alu_srcb;
            4'h2: alu_result = alu_srca + alu_srcb;
            4'h5: alu_result = alu_srca - alu_srcb;
            4'h8: alu_result = {31'd0, alu_srca == alu_srcb};
            4'h9: alu_result = {31'd0, alu_srca != alu_srcb};
            4'hA: alu_result = {31'd0, alu_srca < alu_srcb};
            4'hB: alu_result = {31'd0, alu_srca >= alu_srcb};
            4'hC: alu_result = alu_srca ^ alu_srcb;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
    endtask

    task automatic consume();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_data !== 32'd0) begin failures++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if ({rsp_id, rsp_err} !== 2'b00) begin failures++; $display("FAIL reset_id_err: got %b want 00", {rsp_id, rsp_err}); end
        checks++; if ({op_count0, op_count1} !== 32'd0) begin failures++; $display("FAIL reset_counts: got %h want 0", {op_count0, op_count1}); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'b0010;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
        checks++; if ({alu_srca, alu_srcb, alu_op} !== {32'd5, 32'd3, 4'd2}) begin failures++; $display("FAIL single_alu_mux: got %h %h %h", alu_srca, alu_srcb, alu_op); end
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_a = 32'd99;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
        checks++; if ({rsp_data, rsp_id, rsp_err} !== {32'd8, 1'b0, 1'b0}) begin failures++; $display("FAIL single_rsp: got %h id %b err %b want 8/0/0", rsp_data, rsp_id, rsp_err); end
        checks++; if (alu_op !== 4'd0 || alu_srca !== 32'd0) begin failures++; $display("FAIL single_alu_idle: got %h %h want 0", alu_srca, alu_op); end
        consume();
        exp_c0++;
        checks++; if (op_count0 !== exp_c0) begin failures++; $display("FAIL single_count0: got %0d want %0d", op_count0, exp_c0); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_drop: got %b want 0", rsp_valid); end
    endtask

    task automatic test_idle_rsp_ready();
        @(negedge clk);
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++; if ({op_count0, op_count1} !== {exp_c0, exp_c1}) begin failures++; $display("FAIL idle_ready_counts: got %h want %h", {op_count0, op_count1}, {exp_c0, exp_c1}); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL idle_ready_valid: got %b want 0", rsp_valid); end
    endtask

    task automatic test_contention();
        @(negedge clk);
        reset = 1'b1; #2; reset = 1'b0;
        exp_c0 = 16'd0; exp_c1 = 16'd0;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4; req0_op = 4'b0101;
        req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 4'b1100;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL cont_first_ready: got %b want 10", {req0_ready, req1_ready}); end
        @(posedge clk); #1;
        checks++; if ({rsp_data, rsp_id} !== {32'd6, 1'b0}) begin failures++; $display("FAIL cont_first_rsp: got %h id %b want 6/0", rsp_data, rsp_id); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL cont_resp_ready: got %b want 00", {req0_ready, req1_ready}); end
        consume();
        exp_c0++;
        checks++; if (op_count0 !== exp_c0) begin failures++; $display("FAIL cont_count0: got %0d want %0d", op_count0, exp_c0); end
        checks++; if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin failures++; $display("FAIL cont_second_ready: got %b want 001", {rsp_valid, req0_ready, req1_ready}); end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if ({rsp_data, rsp_id, rsp_err} !== {32'hFF, 1'b1, 1'b0}) begin failures++; $display("FAIL cont_second_rsp: got %h id %b err %b want ff/1/0", rsp_data, rsp_id, rsp_err); end
        consume();
        exp_c1++;
        checks++; if (op_count1 !== exp_c1) begin failures++; $display("FAIL cont_count1: got %0d want %0d", op_count1, exp_c1); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd7; req0_op = 4'b1000;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_op = 4'b1010;
        @(posedge clk); #1;
        checks++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 32'd1, 1'b0}) begin failures++; $display("FAIL bp_first: got v%b %h id %b want 1/1/0", rsp_valid, rsp_data, rsp_id); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid, rsp_data, rsp_id, rsp_err, req0_ready, req1_ready} !== {1'b1, 32'd1, 4'b0000}
                || {op_count0, op_count1} !== {exp_c0, exp_c1}) begin
                failures++;
                $display("FAIL bp_hold_%0d: got v%b %h id%b err%b rdy%b%b cnt %h want 1/1/0/0/00 cnt %h",
                         i, rsp_valid, rsp_data, rsp_id, rsp_err, req0_ready, req1_ready, {op_count0, op_count1}, {exp_c0, exp_c1});
            end
        end
        consume();
        exp_c0++;
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if ({rsp_data, rsp_id} !== {32'd1, 1'b1}) begin failures++; $display("FAIL bp_second: got %h id %b want 1/1", rsp_data, rsp_id); end
        consume();
        exp_c1++;
        checks++; if ({op_count0, op_count1} !== {exp_c0, exp_c1}) begin failures++; $display("FAIL bp_counts: got %h want %h", {op_count0, op_count1}, {exp_c0, exp_c1}); end
    endtask

    task automatic test_unsupported();
        issue(1'b1, 32'd3, 32'd4, 4'b0111);
        checks++; if ({rsp_data, rsp_id, rsp_err} !== {32'd0, 1'b1, 1'b1}) begin failures++; $display("FAIL unsup_rsp: got %h id %b err %b want 0/1/1", rsp_data, rsp_id, rsp_err); end
        consume();
        exp_c1++;
        checks++; if (op_count1 !== exp_c1) begin failures++; $display("FAIL unsup_count1: got %0d want %0d", op_count1, exp_c1); end
    endtask

    task automatic test_opcodes();
        logic [31:0] want_data [16];
        logic        want_err  [16];
        want_data = '{32'h8, 32'hE, 32'h16, 32'h0, 32'h0, 32'h2, 32'h0, 32'h0,
                      32'h0, 32'h1, 32'h0, 32'h1, 32'h6, 32'h0, 32'h0, 32'h0};
        want_err  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 32'hC, 32'hA, 4'(i));
            checks++;
            if ({rsp_data, rsp_err} !== {want_data[i], want_err[i]}) begin
                failures++;
                $display("FAIL opcode_%0h: got %h err %b want %h err %b", i, rsp_data, rsp_err, want_data[i], want_err[i]);
            end
            consume();
            exp_c0++;
        end
        checks++; if (op_count0 !== exp_c0) begin failures++; $display("FAIL opcode_count0: got %0d want %0d", op_count0, exp_c0); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.op_count0 = 16'hFFFE;
        #1;
        release dut.op_count0;
        issue(1'b0, 32'd1, 32'd1, 4'b0010);
        consume();
        checks++; if (op_count0 !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff: got %h want ffff", op_count0); end
        issue(1'b0, 32'd1, 32'd1, 4'b0010);
        consume();
        checks++; if (op_count0 !== 16'h0000) begin failures++; $display("FAIL wrap_zero: got %h want 0000", op_count0); end
    endtask

    task automatic test_async_reset();
        issue(1'b1, 32'd9, 32'd1, 4'b0010);
        checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'hA}) begin failures++; $display("FAIL areset_pre: got v%b %h want 1/a", rsp_valid, rsp_data); end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== 35'd0) begin failures++; $display("FAIL areset_rsp: got v%b %h id %b err %b want all 0", rsp_valid, rsp_data, rsp_id, rsp_err); end
        checks++; if ({op_count0, op_count1} !== 32'd0) begin failures++; $display("FAIL areset_counts: got %h want 0", {op_count0, op_count1}); end
        req0_valid = 1'b1; req0_a = 32'd6; req0_b = 32'd3; req0_op = 4'b0000;
        req1_valid = 1'b1; req1_a = 32'd6; req1_b = 32'd3; req1_op = 4'b0001;
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 32'd2, 1'b0}) begin failures++; $display("FAIL areset_first: got v%b %h id %b want 1/2/0", rsp_valid, rsp_data, rsp_id); end
        consume();
        checks++; if ({op_count0, op_count1} !== {16'd1, 16'd0}) begin failures++; $display("FAIL areset_counts_after: got %h want 00010000", {op_count0, op_count1}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_idle_rsp_ready();
        test_contention();
        test_backpressure();
        test_unsupported();
        test_opcodes();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
